// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared constants, types and helpers for the rate-1/2, K=3
//               convolutional codec (generators 7,5 octal).
// Contents    : NUM_STATES, G0, G1, sym_t, exp_sym(), hamming2()
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  localparam int         NUM_STATES = 4;
  localparam logic [2:0] G0         = 3'b111;
  localparam logic [2:0] G1         = 3'b101;

  // Code symbol: [1] = G0 parity, [0] = G1 parity.
  typedef logic [1:0] sym_t;

  // Encoder output for input bit b leaving state {s1,s0}. The shift register
  // seen by the generators is {b, s1, s0}, newest bit in the MSB.
  function automatic sym_t exp_sym(input logic [1:0] state, input logic b);
    logic [2:0] w_sr;
    w_sr = {b, state};
    return {^(w_sr & G0), ^(w_sr & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input sym_t a, input sym_t b);
    sym_t w_x;
    w_x = a ^ b;
    return {1'b0, w_x[1]} + {1'b0, w_x[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_codec_if.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_codec_if
// Description : Encoder and decoder data/handshake bundle of viterbi_codec.
// Ports       : enc_enable_i, enc_d_i      -> encoder input
//               enc_valid_o, enc_d_o       <- encoder output symbol
//               dec_enable_i, dec_d_i      -> received hard symbol
//               dec_valid_o, dec_d_o       <- decoded bit
// Modports    : master (stimulus side), slave (codec side)
// Revision    : 1.0 - initial release
// ============================================================================
interface viterbi_codec_if;
  import viterbi_pkg::*;

  logic enc_enable_i;
  logic enc_d_i;
  logic enc_valid_o;
  sym_t enc_d_o;
  logic dec_enable_i;
  sym_t dec_d_i;
  logic dec_valid_o;
  logic dec_d_o;

  modport master (
    output enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
    input  enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
  );

  modport slave (
    input  enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
    output enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
  );

endinterface
`default_nettype wire

// File: rtl/viterbi_acs.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_acs
// Description : 4-state add-compare-select for the (7,5) trellis with
//               saturating path metrics and min-normalisation.
// Ports       : i_pm        current path metrics
//               i_sym       received hard symbol
//               o_pm_new    normalised new metrics (best is always 0)
//               o_win       per next state: 0 = pred {x,0}, 1 = pred {x,1}
//               o_best      lowest-index state holding the minimum metric
//               o_min_raw   un-normalised minimum (VITERBI_PM_OUT_EN only)
// Options     : VITERBI_PM_OUT_EN adds o_min_raw
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W = 6
) (
  input  logic [NUM_STATES-1:0][PM_W-1:0] i_pm,
  input  sym_t                            i_sym,
  output logic [NUM_STATES-1:0][PM_W-1:0] o_pm_new,
  output logic [NUM_STATES-1:0]           o_win,
  output logic [1:0]                      o_best
`ifdef VITERBI_PM_OUT_EN
  ,
  output logic [PM_W-1:0]                 o_min_raw
`endif
);

  logic [PM_W-1:0] w_raw [NUM_STATES];
  logic [PM_W-1:0] w_min;
  logic [1:0]      w_best;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0]      b);
    logic [PM_W:0] w_s;
    w_s = {1'b0, a} + {{(PM_W - 1){1'b0}}, b};
    return w_s[PM_W] ? {PM_W{1'b1}} : w_s[PM_W-1:0];
  endfunction

  // Next state {b,x} is reached from {x,0} or {x,1} with input bit b.
  for (genvar gs = 0; gs < NUM_STATES; gs++) begin : g_acs
    localparam logic [1:0] c_ns = 2'(gs);
    localparam logic [1:0] c_p0 = {c_ns[0], 1'b0};
    localparam logic [1:0] c_p1 = {c_ns[0], 1'b1};

    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;

    assign w_c0 = sat_add(i_pm[c_p0], hamming2(exp_sym(c_p0, c_ns[1]), i_sym));
    assign w_c1 = sat_add(i_pm[c_p1], hamming2(exp_sym(c_p1, c_ns[1]), i_sym));

    // Strict compare: a tie keeps predecessor {x,0}.
    assign o_win[gs]    = (w_c1 < w_c0);
    assign w_raw[gs]    = (w_c1 < w_c0) ? w_c1 : w_c0;
    assign o_pm_new[gs] = w_raw[gs] - w_min;
  end

  // Strict compare again so the lowest index wins a tie.
  always_comb begin
    w_min  = w_raw[0];
    w_best = 2'd0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (w_raw[s] < w_min) begin
        w_min  = w_raw[s];
        w_best = 2'(s);
      end
    end
  end

  assign o_best = w_best;

`ifdef VITERBI_PM_OUT_EN
  assign o_min_raw = w_min;
`endif

endmodule
`default_nettype wire

// File: rtl/viterbi_codec.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_codec
// Description : Rate-1/2 K=3 (7,5) convolutional encoder plus an independent
//               hard-decision Viterbi decoder with register-exchange
//               survivors. Decode latency equals TB_DEPTH symbols.
// Ports       : clk, rst        clock, synchronous active-high reset
//               bus (slave)     encoder/decoder data and handshakes
//               dec_min_pm_o    un-normalised best metric of the last step
//                               (VITERBI_PM_OUT_EN only)
// Parameters  : TB_DEPTH  survivor depth / latency in decoded bits
//               PM_W      path-metric width, saturating
// Options     : VITERBI_PM_OUT_EN adds dec_min_pm_o
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_codec
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  viterbi_codec_if.slave   bus
`ifdef VITERBI_PM_OUT_EN
  ,
  output logic [PM_W-1:0]  dec_min_pm_o
`endif
);

  localparam int                  c_fill_w   = $clog2(TB_DEPTH + 1);
  localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(TB_DEPTH);
  localparam logic [c_fill_w-1:0] c_fill_thr = c_fill_w'(TB_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic [1:0] r_enc_s;      // {s1,s0}, s1 = previous information bit
  sym_t       r_enc_sym;
  logic       r_enc_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_s     <= 2'b00;
      r_enc_sym   <= 2'b00;
      r_enc_valid <= 1'b0;
    end else if (bus.enc_enable_i) begin
      r_enc_sym   <= exp_sym(r_enc_s, bus.enc_d_i);
      r_enc_s     <= {bus.enc_d_i, r_enc_s[1]};
      r_enc_valid <= 1'b1;
    end else begin
      r_enc_valid <= 1'b0;
    end
  end

  assign bus.enc_valid_o = r_enc_valid;
  assign bus.enc_d_o     = r_enc_sym;

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  logic [NUM_STATES-1:0][PM_W-1:0]     r_pm;
  // Only the D-1 newest survivor bits need storing: the oldest bit of the
  // shifted survivor is consumed by the output the same cycle it appears.
  logic [NUM_STATES-1:0][TB_DEPTH-2:0] r_sv;
  logic [c_fill_w-1:0]                 r_fill;
  logic                                r_dec_d;
  logic                                r_dec_valid;

  logic [NUM_STATES-1:0][PM_W-1:0]     w_pm_new;
  logic [NUM_STATES-1:0]               w_win;
  logic [1:0]                          w_best;
  logic [NUM_STATES-1:0][TB_DEPTH-1:0] w_sv_new;
`ifdef VITERBI_PM_OUT_EN
  logic [PM_W-1:0]                     w_min_raw;
  logic [PM_W-1:0]                     r_min_pm;
`endif

  viterbi_acs #(
    .PM_W (PM_W)
  ) u_acs (
    .i_pm      (r_pm),
    .i_sym     (bus.dec_d_i),
    .o_pm_new  (w_pm_new),
    .o_win     (w_win),
    .o_best    (w_best)
`ifdef VITERBI_PM_OUT_EN
    ,
    .o_min_raw (w_min_raw)
`endif
  );

  // Register exchange: each next state inherits its winner's history and
  // appends its own decision bit b (the MSB of the next-state index).
  for (genvar gs = 0; gs < NUM_STATES; gs++) begin : g_surv
    localparam logic [1:0] c_ns = 2'(gs);
    assign w_sv_new[gs] = {r_sv[{c_ns[0], w_win[gs]}], c_ns[1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        // Only state 0 is a legal start; the rest begin "unreachable".
        r_pm[s] <= (s == 0) ? {PM_W{1'b0}} : {PM_W{1'b1}};
      end
      r_sv        <= '0;
      r_fill      <= '0;
      r_dec_d     <= 1'b0;
      r_dec_valid <= 1'b0;
    end else if (bus.dec_enable_i) begin
      r_pm <= w_pm_new;
      for (int s = 0; s < NUM_STATES; s++) begin
        r_sv[s] <= w_sv_new[s][TB_DEPTH-2:0];
      end
      r_dec_d <= w_sv_new[w_best][TB_DEPTH-1];
      if (r_fill != c_fill_max) begin
        r_fill <= r_fill + c_fill_w'(1);
      end
      // Valid once the oldest survivor bit belongs to a real symbol.
      r_dec_valid <= (r_fill >= c_fill_thr);
    end else begin
      r_dec_valid <= 1'b0;
    end
  end

`ifdef VITERBI_PM_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_pm <= '0;
    end else if (bus.dec_enable_i) begin
      r_min_pm <= w_min_raw;
    end
  end

  assign dec_min_pm_o = r_min_pm;
`endif

  assign bus.dec_valid_o = r_dec_valid;
  assign bus.dec_d_o     = r_dec_d;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_codec.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_codec
// Description : Self-checking bench for viterbi_codec. Stimulus drives the
//               encoder and a one-register channel into the decoder; expected
//               bits go into queues, monitors pop and compare on valid.
// Options     : VITERBI_PM_OUT_EN also checks dec_min_pm_o
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_codec;
  import viterbi_pkg::*;

  localparam int D    = 16;
  localparam int PM_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  viterbi_codec_if bus ();
`ifdef VITERBI_PM_OUT_EN
  logic [PM_W-1:0] dec_min_pm;
`endif

  viterbi_codec #(
    .TB_DEPTH (D),
    .PM_W     (PM_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef VITERBI_PM_OUT_EN
    ,
    .dec_min_pm_o (dec_min_pm)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;

  bit   dq [$];          // expected decoded bits
  sym_t eq [$];          // expected encoder symbols
  bit   cur   [256];
  bit   stim  [256];
  bit   stim2 [256];

  int   cyc          = 0;
  int   first_acc    = -1;
  bit   first_pending = 1'b0;
  bit   acc_en       = 1'b0;
  bit   rst_s        = 1'b1;
  bit   last_exp     = 1'b0;
  bit   have_last    = 1'b0;
  bit   pm_chk       = 1'b0;
  bit   enc_chk      = 1'b0;
  bit   err_mode     = 1'b0;
  int   sym_idx      = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Edge bookkeeping: what the DUT saw at this edge.
  always @(posedge clk) begin
    cyc++;
    rst_s  = rst;
    acc_en = !rst && bus.dec_enable_i;
    if (rst) begin
      first_acc     = -1;
      first_pending = 1'b1;
      have_last     = 1'b0;
      dq.delete();
    end else if (acc_en && first_acc < 0) begin
      first_acc = cyc;
    end
  end

  // Monitor: outputs sampled mid-cycle.
  always @(negedge clk) begin
    bit   exp_b;
    sym_t exp_s;
    if (!rst_s) begin
      if (!acc_en) begin
        if (have_last) begin
          check("gap_dec_valid_low", bus.dec_valid_o, 0);
          check("gap_dec_d_hold", bus.dec_d_o, last_exp);
        end
      end else if (bus.dec_valid_o) begin
        if (first_pending) begin
          check("first_valid_latency", cyc - first_acc, D - 1);
          first_pending = 1'b0;
        end
        if (dq.size() == 0) begin
          check("dec_extra_output", 1, 0);
        end else begin
          exp_b = dq.pop_front();
          check("dec_bit", bus.dec_d_o, exp_b);
          last_exp  = exp_b;
          have_last = 1'b1;
        end
`ifdef VITERBI_PM_OUT_EN
        if (pm_chk) check("dec_min_pm_clean", dec_min_pm, 0);
`endif
      end
      if (enc_chk && bus.enc_valid_o) begin
        if (eq.size() == 0) begin
          check("enc_extra_output", 1, 0);
        end else begin
          exp_s = eq.pop_front();
          check("enc_sym", bus.enc_d_o, exp_s);
        end
      end
    end
  end

  // One cycle of stimulus: channel forwards last cycle's encoder output.
  task automatic cycle(input bit en, input bit d);
    sym_t ch;
    @(negedge clk);
    ch = bus.enc_d_o;
    if (bus.enc_valid_o) begin
      if (err_mode && (sym_idx % 16 == 15))
        ch = ch ^ (((sym_idx / 16) % 2 == 1) ? 2'b10 : 2'b01);
      sym_idx++;
    end
    bus.dec_enable_i = bus.enc_valid_o;
    bus.dec_d_i      = ch;
    bus.enc_enable_i = en;
    bus.enc_d_i      = d;
    if (en) dq.push_back(d);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst              = 1'b1;
    bus.enc_enable_i = 1'b0;
    bus.enc_d_i      = 1'b0;
    bus.dec_enable_i = 1'b0;
    bus.dec_d_i      = 2'b00;
    eq.delete();
    sym_idx          = 0;
    repeat (n) @(negedge clk);
    check("rst_enc_valid", bus.enc_valid_o, 0);
    check("rst_enc_d", bus.enc_d_o, 0);
    check("rst_dec_valid", bus.dec_valid_o, 0);
    check("rst_dec_d", bus.dec_d_o, 0);
`ifdef VITERBI_PM_OUT_EN
    check("rst_dec_min_pm", dec_min_pm, 0);
`endif
    rst = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit gaps, input bit tail);
    bit gapm [256];
    int k;
    int p;
    for (int i = 0; i < 256; i++) gapm[i] = 1'b0;
    if (gaps) begin
      k = 0;
      while (k < 5) begin
        p = $urandom_range(230, 20);
        if (!gapm[p]) begin
          gapm[p] = 1'b1;
          k++;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      if (gapm[i]) cycle(1'b0, 1'b0);
      cycle(1'b1, cur[i]);
    end
    if (tail) begin
      repeat (4) cycle(1'b0, 1'b0);
      check("dec_pending_count", dq.size(), D - 1);
    end
  endtask

  initial begin
    bus.enc_enable_i = 1'b0;
    bus.enc_d_i      = 1'b0;
    bus.dec_enable_i = 1'b0;
    bus.dec_d_i      = 2'b00;
    for (int i = 0; i < 256; i++) begin
      stim[i]  = 1'($urandom_range(1, 0));
      stim2[i] = 1'($urandom_range(1, 0));
    end

    // Reset held three cycles.
    do_reset(3);

    // Directed encoder vector from state 00.
    enc_chk = 1'b1;
    eq.push_back(2'b11); eq.push_back(2'b10); eq.push_back(2'b00);
    eq.push_back(2'b01); eq.push_back(2'b01); eq.push_back(2'b11);
    cycle(1'b1, 1'b1); cycle(1'b1, 1'b0); cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0); cycle(1'b0, 1'b0);
    check("enc_pending_count", eq.size(), 0);
    check("enc_valid_idle", bus.enc_valid_o, 0);
    check("enc_d_hold", bus.enc_d_o, 2'b11);
    enc_chk = 1'b0;

    // Clean loopback.
    for (int i = 0; i < 256; i++) cur[i] = stim[i];
    do_reset(2);
    pm_chk = 1'b1;
    run_stream(256, 1'b0, 1'b1);
    pm_chk = 1'b0;

    // One flipped bit in every 16th symbol.
    do_reset(2);
    err_mode = 1'b1;
    run_stream(256, 1'b0, 1'b1);
    err_mode = 1'b0;

    // Same stream with five enable gaps.
    do_reset(2);
    run_stream(256, 1'b1, 1'b1);

    // Reset at symbol 100, then a fresh stream.
    do_reset(2);
    run_stream(100, 1'b0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 256; i++) cur[i] = stim2[i];
    run_stream(128, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
